// File: rtl/pulse_interrupter_pkg.sv
// Shared state encoding and default clamp constants for the pulse interrupter.
package interrupter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int              DEF_CW             = 32;
  localparam longint unsigned DEF_MAX_ON_CYCLES  = 5000;
  localparam longint unsigned DEF_MIN_OFF_CYCLES = 100000;
  localparam int              BW                 = 16;

endpackage

// File: rtl/pulse_interrupter_if.sv
// Control-side bus of the pulse interrupter; burst fields exist only with INTERRUPTER_BURST_EN.
interface pulse_interrupter_if
  import interrupter_pkg::*;
#(
  parameter int CW = DEF_CW
) ();

  logic          enable;
  logic [CW-1:0] on_cycles;
  logic [CW-1:0] off_cycles;
`ifdef INTERRUPTER_BURST_EN
  logic [BW-1:0] burst_pulses;
  logic [CW-1:0] burst_gap;
`endif
  logic          out;
  logic          pulse_start;
  logic          clamped;
  logic          busy;

`ifdef INTERRUPTER_BURST_EN
  modport master (output enable, on_cycles, off_cycles, burst_pulses, burst_gap,
                  input  out, pulse_start, clamped, busy);
  modport slave  (input  enable, on_cycles, off_cycles, burst_pulses, burst_gap,
                  output out, pulse_start, clamped, busy);
`else
  modport master (output enable, on_cycles, off_cycles,
                  input  out, pulse_start, clamped, busy);
  modport slave  (input  enable, on_cycles, off_cycles,
                  output out, pulse_start, clamped, busy);
`endif

endinterface

// File: rtl/pulse_interrupter_timer.sv
// Down-counter used for phase timing: load value-1, count to zero, expired at zero.
module interrupter_timer
  import interrupter_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [CW-1:0] value_i,
  input  logic          dec_i,
  output logic          expired_o
);

  logic [CW-1:0] count_q, count_d;

  // A zero-length load saturates so the phase still lasts one cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = (value_i == '0) ? '0 : value_i - CW'(1);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/pulse_interrupter.sv
// Pulse interrupter: clamped on/off pulse train gating the coil gate-drive enable.
// Optional burst mode (groups of pulses separated by an extra gap) under INTERRUPTER_BURST_EN.
module pulse_interrupter
  import interrupter_pkg::*;
#(
  parameter int              CW             = DEF_CW,
  parameter longint unsigned MAX_ON_CYCLES  = DEF_MAX_ON_CYCLES,
  parameter longint unsigned MIN_OFF_CYCLES = DEF_MIN_OFF_CYCLES
) (
  input logic                clock,
  input logic                reset_n,
  pulse_interrupter_if.slave bus
);

  if (CW < 1 || CW > 64) begin : g_cw_check
    $error("pulse_interrupter: CW must be within 1..64");
  end
  if ((MAX_ON_CYCLES >> CW) != 0) begin : g_max_on_check
    $error("pulse_interrupter: MAX_ON_CYCLES does not fit in CW bits");
  end
  if ((MIN_OFF_CYCLES >> CW) != 0) begin : g_min_off_check
    $error("pulse_interrupter: MIN_OFF_CYCLES does not fit in CW bits");
  end

  localparam logic [CW-1:0] MAX_ON  = CW'(MAX_ON_CYCLES);
  localparam logic [CW-1:0] MIN_OFF = CW'(MIN_OFF_CYCLES);

  state_t        state_q, state_d;
  logic [CW-1:0] off_sh_q, off_sh_d;
  logic          out_q, out_d;
  logic          pulse_start_q, pulse_start_d;
  logic          clamped_q, clamped_d;

  logic [CW-1:0] on_clamped, off_clamped;
  logic          clamp_hit;
  logic          period_start;

  logic          ph_clear, ph_load, ph_dec, ph_expired;
  logic [CW-1:0] ph_value;

  assign on_clamped  = (bus.on_cycles > MAX_ON) ? MAX_ON : bus.on_cycles;
  assign off_clamped = (bus.off_cycles < MIN_OFF) ? MIN_OFF : bus.off_cycles;
  assign clamp_hit   = (bus.on_cycles > MAX_ON) || (bus.off_cycles < MIN_OFF);

  interrupter_timer #(.CW(CW)) u_phase_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_i   (ph_clear),
    .load_i    (ph_load),
    .value_i   (ph_value),
    .dec_i     (ph_dec),
    .expired_o (ph_expired)
  );

`ifdef INTERRUPTER_BURST_EN
  logic [BW-1:0] bp_q, bp_d, pcnt_q, pcnt_d;
  logic [CW-1:0] bg_q, bg_d;
  logic          gap_pend_q, gap_pend_d;
  logic          gap_clear, gap_load, gap_dec, gap_expired;
  logic          burst_on;

  // A zero pulse count or zero gap means plain continuous operation.
  assign burst_on = (bp_q != '0) && (bg_q != '0);

  interrupter_timer #(.CW(CW)) u_gap_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_i   (gap_clear),
    .load_i    (gap_load),
    .value_i   (bg_q),
    .dec_i     (gap_dec),
    .expired_o (gap_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bp_q       <= '0;
      bg_q       <= '0;
      pcnt_q     <= '0;
      gap_pend_q <= 1'b0;
    end else begin
      bp_q       <= bp_d;
      bg_q       <= bg_d;
      pcnt_q     <= pcnt_d;
      gap_pend_q <= gap_pend_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    off_sh_d     = off_sh_q;
    period_start = 1'b0;
    ph_clear     = 1'b0;
    ph_load      = 1'b0;
    ph_dec       = 1'b0;
    ph_value     = on_clamped;
`ifdef INTERRUPTER_BURST_EN
    bp_d         = bp_q;
    bg_d         = bg_q;
    pcnt_d       = pcnt_q;
    gap_pend_d   = gap_pend_q;
    gap_clear    = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
`endif
    if (!bus.enable) begin
      state_d  = IDLE;
      ph_clear = 1'b1;
`ifdef INTERRUPTER_BURST_EN
      gap_clear  = 1'b1;
      pcnt_d     = '0;
      gap_pend_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: period_start = 1'b1;
        ON: begin
          if (ph_expired) begin
            state_d  = OFF;
            ph_load  = 1'b1;
            ph_value = off_sh_q;
`ifdef INTERRUPTER_BURST_EN
            if (burst_on) begin
              pcnt_d = pcnt_q + BW'(1);
              if (pcnt_d == bp_q) gap_pend_d = 1'b1;
            end
`endif
          end else begin
            ph_dec = 1'b1;
          end
        end
        OFF: begin
          if (ph_expired) begin
`ifdef INTERRUPTER_BURST_EN
            if (gap_pend_q) begin
              state_d  = GAP;
              gap_load = 1'b1;
            end else begin
              period_start = 1'b1;
            end
`else
            period_start = 1'b1;
`endif
          end else begin
            ph_dec = 1'b1;
          end
        end
`ifdef INTERRUPTER_BURST_EN
        GAP: begin
          if (gap_expired) begin
            period_start = 1'b1;
            pcnt_d       = '0;
            gap_pend_d   = 1'b0;
          end else begin
            gap_dec = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase

      // Shadows are captured only here; inputs are ignored for the rest of the period.
      if (period_start) begin
        off_sh_d = off_clamped;
        ph_load  = 1'b1;
        if (on_clamped != '0) begin
          state_d  = ON;
          ph_value = on_clamped;
        end else begin
          state_d  = OFF;
          ph_value = off_clamped;
        end
`ifdef INTERRUPTER_BURST_EN
        if (pcnt_d == '0) begin
          bp_d = bus.burst_pulses;
          bg_d = bus.burst_gap;
        end
`endif
      end
    end

    out_d         = (state_d == ON);
    pulse_start_d = period_start && (on_clamped != '0);
    clamped_d     = period_start && clamp_hit;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      off_sh_q      <= '0;
      out_q         <= 1'b0;
      pulse_start_q <= 1'b0;
      clamped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      off_sh_q      <= off_sh_d;
      out_q         <= out_d;
      pulse_start_q <= pulse_start_d;
      clamped_q     <= clamped_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.pulse_start = pulse_start_q;
  assign bus.clamped     = clamped_q;
  assign bus.busy        = (state_q != IDLE);

endmodule
